// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer: op codes,
// controller states and fault codes.
package microseq_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_CALLO = 2'b01,
    OP_CALLF = 2'b10,
    OP_BRZ   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_OVF  = 2'd1;
  localparam logic [1:0] FC_SEG  = 2'd2;
  localparam logic [1:0] FC_IP   = 2'd3;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/microsequencer_stack.sv
// Return-address stack for the microsequencer.
// o_top is the most recently pushed entry.
module ucall_stack #(
  parameter int D = 8,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_top,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(D + 1);
  localparam int IW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  r_mem [D];
  logic [PW-1:0] r_sp;
  logic [PW-1:0] w_spm1;

  assign o_full  = (r_sp == PW'(D));
  assign o_empty = (r_sp == '0);
  assign w_spm1  = r_sp - 1'b1;
  assign o_top   = r_mem[w_spm1[IW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sp <= '0;
    end else if (i_push && !o_full) begin
      r_sp <= r_sp + 1'b1;
    end else if (i_pop && !o_empty) begin
      r_sp <= r_sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) begin
      r_mem[r_sp[IW-1:0]] <= i_din;
    end
  end

  logic w_unused;
  assign w_unused = ^{w_spm1, r_sp};

endmodule

// File: rtl/microsequencer.sv
// Microcode sequencer: segment start tables, a
// call stack, and NOP/CALL/BRZ microword flow.
module microsequencer
  import microseq_pkg::*;
#(
  parameter  int CTRL_W  = 32,
  parameter  int DEPTH   = 256,
  parameter  int STACK_D = 8,
  parameter  int OPC_W   = 6,
  parameter  int FN_W    = 6,
  localparam int AW      = $clog2(DEPTH),
  localparam int SW      = max2(OPC_W, FN_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uc_we,
  input  logic [AW-1:0]        uc_waddr,
  input  logic [AW+CTRL_W+2:0] uc_wdata,
  input  logic                 seg_we,
  input  logic                 seg_sel,
  input  logic [SW-1:0]        seg_waddr,
  input  logic [AW:0]          seg_wdata,
  input  logic [OPC_W-1:0]     opcode,
  input  logic                 sos,
  input  logic                 cond,
  output logic [CTRL_W-1:0]    ctrl,
  output logic                 eos,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault,
  output logic [1:0]           fault_code
);

  localparam int WW = AW + CTRL_W + 3;
  localparam int XW = max2(AW, SW);

  logic [WW-1:0]      r_code  [DEPTH];
  logic [AW-1:0]      r_oaddr [2**OPC_W];
  logic [AW-1:0]      r_faddr [2**FN_W];
  logic [2**OPC_W-1:0] r_ovld;
  logic [2**FN_W-1:0]  r_fvld;

  state_e      r_state, w_state_n;
  logic [AW-1:0] r_ip, w_ip_n;
  logic [1:0]  r_fc, w_fc_n;

  logic [WW-1:0]     w_word;
  op_e               w_op;
  logic [AW-1:0]     w_tgt;
  logic              w_eosb;
  logic [CTRL_W-1:0] w_ctrl;
  logic [XW-1:0]     w_tx;
  logic [OPC_W-1:0]  w_oidx;
  logic [FN_W-1:0]   w_fidx;
  logic              w_iscall;
  logic              w_sv;
  logic [AW-1:0]     w_sa;
  logic              w_last;
  logic              w_push, w_pop, w_eos;
  logic [AW-1:0]     w_ret, w_top;
  logic              w_full, w_empty;

  always_ff @(posedge clk) begin
    if (uc_we) begin
      r_code[uc_waddr] <= uc_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (seg_we && !seg_sel) begin
      r_oaddr[seg_waddr[OPC_W-1:0]] <= seg_wdata[AW-1:0];
    end
    if (seg_we && seg_sel) begin
      r_faddr[seg_waddr[FN_W-1:0]] <= seg_wdata[AW-1:0];
    end
  end

  // Only the valid bits reset; stored addresses are don't-care until revalidated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovld <= '0;
      r_fvld <= '0;
    end else if (seg_we) begin
      if (seg_sel) begin
        r_fvld[seg_waddr[FN_W-1:0]] <= seg_wdata[AW];
      end else begin
        r_ovld[seg_waddr[OPC_W-1:0]] <= seg_wdata[AW];
      end
    end
  end

  assign w_word   = r_code[r_ip];
  assign w_op     = op_e'(w_word[WW-1 -: 2]);
  assign w_tgt    = w_word[CTRL_W+1 +: AW];
  assign w_eosb   = w_word[CTRL_W];
  assign w_ctrl   = w_word[CTRL_W-1:0];
  assign w_tx     = XW'(w_tgt);
  assign w_oidx   = (r_state == S_IDLE) ? opcode : w_tx[OPC_W-1:0];
  assign w_fidx   = w_tx[FN_W-1:0];
  assign w_iscall = (w_op == OP_CALLO) || (w_op == OP_CALLF);
  assign w_sv     = (w_op == OP_CALLF) ? r_fvld[w_fidx] : r_ovld[w_oidx];
  assign w_sa     = (w_op == OP_CALLF) ? r_faddr[w_fidx] : r_oaddr[w_oidx];
  assign w_last   = (r_ip == AW'(DEPTH - 1));
  assign w_ret    = r_ip + 1'b1;

  ucall_stack #(
    .D (STACK_D),
    .W (AW)
  ) u_stack (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_ret),
    .o_top   (w_top),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ip    <= '0;
      r_fc    <= FC_NONE;
    end else begin
      r_state <= w_state_n;
      r_ip    <= w_ip_n;
      r_fc    <= w_fc_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_ip_n    = r_ip;
    w_fc_n    = r_fc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_eos     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (sos) begin
          if (&opcode) begin
            w_state_n = S_HALT;
          end else if (r_ovld[opcode]) begin
            w_ip_n    = r_oaddr[opcode];
            w_state_n = S_RUN;
          end else begin
            w_state_n = S_FAULT;
            w_fc_n    = FC_SEG;
          end
        end
      end
      S_RUN: begin
        // A CALL carrying eos is a tail call: jump, keep the caller's frame.
        if (w_iscall) begin
          if (!w_sv) begin
            w_state_n = S_FAULT;
            w_fc_n    = FC_SEG;
          end else if (!w_eosb && w_full) begin
            w_state_n = S_FAULT;
            w_fc_n    = FC_OVF;
          end else begin
            w_ip_n = w_sa;
            w_push = !w_eosb;
          end
        end else if (w_eosb) begin
          if (w_empty) begin
            w_state_n = S_IDLE;
            w_eos     = 1'b1;
          end else begin
            w_ip_n = w_top;
            w_pop  = 1'b1;
          end
        end else if (w_op == OP_BRZ && !cond) begin
          w_ip_n = w_tgt;
        end else if (w_last) begin
          w_state_n = S_FAULT;
          w_fc_n    = FC_IP;
        end else begin
          w_ip_n = w_ret;
        end
      end
      default: begin
      end
    endcase
  end

  assign ctrl       = (r_state == S_RUN) ? w_ctrl : '0;
  assign eos        = w_eos;
  assign busy       = (r_state == S_RUN);
  assign halted     = (r_state == S_HALT);
  assign fault      = (r_state == S_FAULT);
  assign fault_code = r_fc;

  logic w_unused;
  assign w_unused = ^{w_tx, seg_waddr};

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed
// scenarios plus random programs against a model.
module tb_microsequencer;

  localparam int CW   = 16;
  localparam int D    = 64;
  localparam int SD   = 2;
  localparam int AW   = 6;
  localparam int MAXS = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          uc_we = 1'b0;
  logic [AW-1:0] uc_waddr = '0;
  logic [AW+CW+2:0] uc_wdata = '0;
  logic          seg_we = 1'b0;
  logic          seg_sel = 1'b0;
  logic [5:0]    seg_waddr = '0;
  logic [AW:0]   seg_wdata = '0;
  logic [5:0]    opcode = '0;
  logic          sos = 1'b0;
  logic          cond = 1'b0;
  logic [CW-1:0] ctrl;
  logic          eos, busy, halted, fault;
  logic [1:0]    fault_code;

  int n_chk = 0;
  int n_fail = 0;

  int m_op [D];
  int m_tgt [D];
  int m_eos [D];
  int m_ctrl [D];
  bit ov [64];
  int oa [64];
  bit fv [16];
  int fa [16];
  int exp_c [$];
  bit exp_e [$];

  microsequencer #(
    .CTRL_W  (CW),
    .DEPTH   (D),
    .STACK_D (SD),
    .OPC_W   (6),
    .FN_W    (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uc_we      (uc_we),
    .uc_waddr   (uc_waddr),
    .uc_wdata   (uc_wdata),
    .seg_we     (seg_we),
    .seg_sel    (seg_sel),
    .seg_waddr  (seg_waddr),
    .seg_wdata  (seg_wdata),
    .opcode     (opcode),
    .sos        (sos),
    .cond       (cond),
    .ctrl       (ctrl),
    .eos        (eos),
    .busy       (busy),
    .halted     (halted),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wr_word(input int a, input int op, input int t,
                         input int e, input int c);
    m_op[a] = op; m_tgt[a] = t; m_eos[a] = e; m_ctrl[a] = c;
    @(negedge clk);
    uc_we = 1'b1;
    uc_waddr = a[AW-1:0];
    uc_wdata = {op[1:0], t[5:0], e[0], c[15:0]};
    @(posedge clk);
    #1 uc_we = 1'b0;
  endtask

  task automatic wr_seg(input int sel, input int idx, input int v, input int a);
    if (sel == 0) begin ov[idx] = v[0]; oa[idx] = a; end
    else begin fv[idx] = v[0]; fa[idx] = a; end
    @(negedge clk);
    seg_we = 1'b1;
    seg_sel = sel[0];
    seg_waddr = idx[5:0];
    seg_wdata = {v[0], a[5:0]};
    @(posedge clk);
    #1 seg_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sos = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) ov[i] = 1'b0;
    for (int i = 0; i < 16; i++) fv[i] = 1'b0;
  endtask

  // Interprets the program; fc: 0 done, 1-3 fault, 4 halt, 5 still running.
  task automatic model_seg(input int opc, input bit c, output int fc);
    int ip, op, idx, v, a;
    int stk [$];
    exp_c = {};
    exp_e = {};
    fc = 5;
    if (opc == 63) begin fc = 4; return; end
    if (!ov[opc]) begin fc = 2; return; end
    ip = oa[opc];
    for (int n = 0; n < MAXS; n++) begin
      exp_c.push_back(m_ctrl[ip]);
      exp_e.push_back(1'b0);
      op = m_op[ip];
      if (op == 1 || op == 2) begin
        idx = (op == 1) ? m_tgt[ip] % 64 : m_tgt[ip] % 16;
        v = (op == 1) ? int'(ov[idx]) : int'(fv[idx]);
        a = (op == 1) ? oa[idx] : fa[idx];
        if (v == 0) begin fc = 2; return; end
        if (m_eos[ip] == 0) begin
          if (stk.size() == SD) begin fc = 1; return; end
          stk.push_back(ip + 1);
        end
        ip = a;
      end else if (m_eos[ip] != 0) begin
        if (stk.size() == 0) begin
          exp_e[exp_e.size() - 1] = 1'b1;
          fc = 0;
          return;
        end
        ip = stk.pop_back();
      end else if (op == 3 && !c) begin
        ip = m_tgt[ip];
      end else if (ip == D - 1) begin
        fc = 3;
        return;
      end else begin
        ip = ip + 1;
      end
    end
  endtask

  task automatic run_segment(input int opc, input bit c, input string nm);
    int fc;
    model_seg(opc, c, fc);
    @(negedge clk);
    opcode = opc[5:0];
    cond = c;
    sos = 1'b1;
    @(negedge clk);
    sos = 1'b0;
    for (int k = 0; k < exp_c.size(); k++) begin
      n_chk++;
      if (ctrl !== CW'(exp_c[k]) || eos !== exp_e[k] || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s step %0d: got ctrl=%h eos=%b busy=%b, want ctrl=%h eos=%b busy=1",
                 nm, k, ctrl, eos, busy, CW'(exp_c[k]), exp_e[k]);
      end
      @(negedge clk);
    end
    n_chk++;
    case (fc)
      0: if (busy !== 1'b0 || fault !== 1'b0 || ctrl !== '0 || eos !== 1'b0) begin
        n_fail++;
        $display("FAIL %s end: got busy=%b fault=%b ctrl=%h eos=%b, want idle zeros",
                 nm, busy, fault, ctrl, eos);
      end
      1, 2, 3: if (fault !== 1'b1 || fault_code !== 2'(fc) || ctrl !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s fault: got fault=%b code=%0d ctrl=%h busy=%b, want fault=1 code=%0d ctrl=0",
                 nm, fault, fault_code, ctrl, busy, fc);
      end
      4: if (halted !== 1'b1 || busy !== 1'b0 || ctrl !== '0) begin
        n_fail++;
        $display("FAIL %s halt: got halted=%b busy=%b ctrl=%h, want halted=1",
                 nm, halted, busy, ctrl);
      end
      default: if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s running: got busy=%b, want 1", nm, busy);
      end
    endcase
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({ctrl, eos, busy, halted, fault, fault_code} !== '0) begin
      n_fail++;
      $display("FAIL reset: got ctrl=%h eos=%b busy=%b halted=%b fault=%b code=%0d, want all 0",
               ctrl, eos, busy, halted, fault, fault_code);
    end
  endtask

  task automatic test_basic();
    wr_seg(0, 3, 1, 10);
    wr_word(10, 0, 0, 0, 'h4);
    wr_word(11, 0, 0, 1, 'h8);
    @(negedge clk);
    opcode = 6'd3; cond = 1'b0; sos = 1'b1;
    @(negedge clk);
    sos = 1'b0;
    n_chk++;
    if (ctrl !== 16'h4 || busy !== 1'b1 || eos !== 1'b0) begin
      n_fail++;
      $display("FAIL basic w0: got ctrl=%h busy=%b eos=%b, want 4 1 0", ctrl, busy, eos);
    end
    @(negedge clk);
    n_chk++;
    if (ctrl !== 16'h8 || busy !== 1'b1 || eos !== 1'b1) begin
      n_fail++;
      $display("FAIL basic w1: got ctrl=%h busy=%b eos=%b, want 8 1 1", ctrl, busy, eos);
    end
    @(negedge clk);
    n_chk++;
    if (ctrl !== 16'h0 || busy !== 1'b0 || eos !== 1'b0) begin
      n_fail++;
      $display("FAIL basic end: got ctrl=%h busy=%b eos=%b, want 0 0 0", ctrl, busy, eos);
    end
    run_segment(3, 1'b1, "basic_model");
  endtask

  task automatic test_call();
    wr_seg(0, 4, 1, 20);
    wr_seg(1, 2, 1, 40);
    wr_word(20, 2, 2, 0, 'h5);
    wr_word(40, 0, 0, 1, 'h1);
    wr_word(21, 0, 0, 1, 'h2);
    run_segment(4, 1'b0, "callf");
    wr_seg(0, 12, 1, 24);
    wr_word(24, 2, 2, 1, 'h24);
    run_segment(12, 1'b0, "tailcall");
  endtask

  task automatic test_brz();
    wr_seg(0, 6, 1, 5);
    wr_word(5, 3, 9, 0, 'h55);
    wr_word(6, 0, 0, 1, 'h66);
    wr_word(9, 0, 0, 1, 'h99);
    run_segment(6, 1'b0, "brz_taken");
    run_segment(6, 1'b1, "brz_fall");
    wr_word(5, 3, 9, 1, 'h57);
    run_segment(6, 1'b0, "brz_eos");
  endtask

  task automatic test_faults();
    wr_seg(0, 10, 1, 62);
    wr_word(62, 0, 0, 0, 'h62);
    wr_word(63, 0, 0, 0, 'h63);
    run_segment(10, 1'b0, "overrun");
    do_reset();
    wr_seg(0, 5, 1, 30);
    wr_word(30, 1, 5, 0, 'h30);
    run_segment(5, 1'b0, "overflow");
    do_reset();
    wr_seg(0, 5, 1, 30);
    wr_word(30, 1, 7, 0, 'h31);
    run_segment(5, 1'b0, "call_invalid");
    do_reset();
    run_segment(9, 1'b0, "sos_invalid");
    do_reset();
  endtask

  task automatic test_halt();
    wr_seg(0, 3, 1, 10);
    run_segment(63, 1'b0, "halt");
    @(negedge clk);
    opcode = 6'd3; sos = 1'b1;
    @(negedge clk);
    sos = 1'b0;
    n_chk++;
    if (halted !== 1'b1 || busy !== 1'b0 || ctrl !== '0) begin
      n_fail++;
      $display("FAIL halt_sos: got halted=%b busy=%b ctrl=%h, want 1 0 0", halted, busy, ctrl);
    end
    do_reset();
    n_chk++;
    if (halted !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_reset: got halted=%b fault=%b, want 0 0", halted, fault);
    end
  endtask

  task automatic test_reset_mid();
    wr_seg(0, 8, 1, 50);
    wr_seg(0, 9, 1, 52);
    wr_word(50, 1, 9, 0, 'h50);
    wr_word(51, 0, 0, 1, 'h51);
    wr_word(52, 0, 0, 0, 'h52);
    wr_word(53, 0, 0, 1, 'h53);
    @(negedge clk);
    opcode = 6'd8; cond = 1'b0; sos = 1'b1;
    @(negedge clk);
    sos = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ctrl !== 16'h52 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got ctrl=%h busy=%b, want 52 1", ctrl, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) ov[i] = 1'b0;
    for (int i = 0; i < 16; i++) fv[i] = 1'b0;
    n_chk++;
    if ({ctrl, eos, busy, halted, fault, fault_code} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got ctrl=%h eos=%b busy=%b fault=%b, want all 0",
               ctrl, eos, busy, fault);
    end
    wr_seg(0, 8, 1, 50);
    wr_seg(0, 9, 1, 52);
    run_segment(8, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      do_reset();
      for (int a = 0; a < D; a++) begin
        wr_word(a, $urandom_range(0, 3), $urandom_range(0, 63),
                ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 65535));
      end
      for (int i = 0; i < 63; i++) begin
        wr_seg(0, i, ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 63));
      end
      for (int i = 0; i < 16; i++) begin
        wr_seg(1, i, ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 63));
      end
      run_segment($urandom_range(0, 63), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_call();
    test_brz();
    test_faults();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 SHALL have parameters: CTRL_W, default 32, control bus width; DEPTH, default 256, microword count; STACK_D, default 8, call-stack entries; OPC_W, default 6, opcode width; FN_W, default 6, function-table index width.
REQ-002 SHALL derive AW = clog2(DEPTH); microword = {op[1:0], target[AW-1:0], eos, ctrl[CTRL_W-1:0]}.
REQ-003 Ports, one per line:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- uc_we  in  1  microword write strobe.
- uc_waddr  in  AW  microword write address.
- uc_wdata  in  AW+CTRL_W+3  microword write data.
- seg_we  in  1  segment-table write strobe.
- seg_sel  in  1  0 = opcode table, 1 = function table.
- seg_waddr  in  max(OPC_W,FN_W)  table index.
- seg_wdata  in  AW+1  {valid, start address}.
- opcode  in  OPC_W  instruction opcode.
- sos  in  1  start-of-segment request.
- cond  in  1  datapath condition flag.
- ctrl  out  CTRL_W  control bus.
- eos  out  1  segment-complete pulse.
- busy  out  1  sequencer running.
- halted  out  1  halt opcode seen.
- fault  out  1  sticky error.
- fault_code  out  2  1 = stack overflow, 2 = invalid segment, 3 = ip overrun.

Function
REQ-004 SHALL implement states IDLE, RUN, HALT, FAULT.
REQ-005 Microword and table writes SHALL take effect at the clock edge, in any state, and SHALL be visible to reads in the following cycle.
REQ-006 In IDLE, sos=1 with opcode = all-ones SHALL enter HALT; the sequencer SHALL stay in HALT until reset.
REQ-007 In IDLE, sos=1 with a valid opcode-table entry SHALL load ip with the start address and enter RUN at the same edge.
REQ-008 In IDLE, sos=1 with an invalid opcode-table entry SHALL enter FAULT with code 2.
REQ-009 ctrl SHALL equal the ctrl field of code[ip] combinationally while in RUN, and 0 in every other state; the first control word SHALL appear the cycle after the sos edge.
REQ-010 op 00 (NOP) in RUN:
- eos=0: ip <= ip+1.
- ip = DEPTH-1: enter FAULT, code 3.
REQ-011 op 01 / 10 (CALL) SHALL index the opcode table / function table with target[OPC_W-1:0] / target[FN_W-1:0], push ip+1 and jump to the start address.
REQ-012 CALL with an invalid table entry SHALL enter FAULT, code 2.
REQ-013 CALL with the stack holding STACK_D entries SHALL enter FAULT, code 1, with no push.
REQ-014 op 11 (BRZ) SHALL set ip <= target when cond=0, and ip <= ip+1 otherwise.
REQ-015 eos=1 with a non-empty stack SHALL pop the stack into ip.
REQ-016 eos=1 with an empty stack SHALL return to IDLE and pulse eos high for exactly that cycle.
REQ-017 CALL with eos=1 SHALL be a tail call: jump without pushing.
REQ-018 BRZ with eos=1: eos takes priority; the branch is ignored.
REQ-019 sos SHALL be ignored outside IDLE.
REQ-020 An sos held high for several cycles SHALL start only one segment per IDLE entry.
REQ-021 busy SHALL be 1 exactly in RUN.
REQ-022 halted SHALL be 1 exactly in HALT.
REQ-023 fault SHALL be 1 exactly in FAULT; FAULT exits only via reset.

Reset
REQ-024 rst_n=0 at an edge SHALL force IDLE, ip=0, stack pointer=0 and fault_code=0, aborting any segment in flight.
REQ-025 After reset, outputs SHALL be ctrl=0, eos=0, busy=0, halted=0, fault=0.
REQ-026 Reset SHALL clear the valid bits of both segment tables; microword contents SHALL be preserved.

Structure
REQ-027 A shared package microseq_pkg SHALL hold the op encodings (NOP, CALLO, CALLF, BRZ), the state enum and the fault_code constants.
REQ-028 The call stack SHALL be a sub-module, ucall_stack, parametrised by depth and width, with push, pop, full and empty.

Verification
REQ-029 Load opcode 3 -> address 10; word 10 ctrl=0x4, word 11 ctrl=0x8 with eos; sos with opcode=3 -> ctrl 0x4 then 0x8, eos pulse, then ctrl=0 with busy=0.
REQ-030 Word 20 CALLF idx 2 (func table 2 -> 40); word 40 ctrl=0x1 with eos; word 21 ctrl=0x2 with eos -> ctrl sequence 0x?(20), 0x1, 0x2, then eos.
REQ-031 STACK_D=2 with a recursive CALL chain -> third CALL gives fault=1 and fault_code=1; ctrl=0 thereafter.
REQ-032 BRZ at word 5, target 9: cond=0 -> next ctrl from word 9; cond=1 -> next ctrl from word 6.
REQ-033 sos with opcode=0x3F -> halted=1; subsequent sos is ignored; rst_n=0 -> halted=0.
REQ-034 Assert rst_n=0 mid-segment with stack depth 1 -> IDLE next cycle, outputs 0; a new sos runs correctly from an empty stack.
